// File: rtl/alu_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} working pair: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opb_i,
    output logic [XLEN-1:0] hi_c_o,
    output logic [XLEN-1:0] lo_c_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi_i} + ({1'b0, opb_i} & {(XLEN+1){lo_i[0]}});
        shifted = {hi_i, lo_i[XLEN-1]};
        diff    = shifted - {1'b0, opb_i};
        if (is_div_i) begin
            // Remainder stays below the divisor, so a non-negative diff fits XLEN bits.
            if (!diff[XLEN]) begin
                hi_c_o = diff[XLEN-1:0];
                lo_c_o = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                hi_c_o = shifted[XLEN-1:0];
                lo_c_o = {lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_c_o = sum[XLEN:1];
            lo_c_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide: operands are made unsigned on entry, XLEN
// radix-2 steps run in CALC, and the sign is restored when the result is written.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] ALU_result,
    output logic            zero
);

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    op_e               op_in;
    logic              sgn_a, sgn_b, neg_a_in, neg_b_in;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   result_c;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (op_q[2]),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .opb_i    (opb_q),
        .hi_c_o   (step_hi),
        .lo_c_o   (step_lo)
    );

    // Sign-corrected result of the final iteration, selected by the latched op.
    always_comb begin
        prod = {step_hi, step_lo};
        if (neg_a_q ^ neg_b_q) begin
            prod = -prod;
        end
        quo = (neg_a_q ^ neg_b_q) ? -step_lo : step_lo;
        rem = neg_a_q ? -step_hi : step_hi;
        case (op_q)
            OP_MUL:                       result_c = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_c = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result_c = quo;
            default:                      result_c = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        res_d    = res_q;

        op_in    = op_e'(op);
        sgn_a    = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                   (op_in == OP_DIV)  || (op_in == OP_REM);
        sgn_b    = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        neg_a_in = sgn_a & A[XLEN-1];
        neg_b_in = sgn_b & B[XLEN-1];
        div_zero = op[2] && (B == '0);
        div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) && (A == SMIN) && (B == '1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = op_in;
                    if (div_zero) begin
                        res_d   = op[1] ? A : '1;
                        state_d = ST_DONE;
                    end else if (div_ovf) begin
                        res_d   = op[1] ? '0 : A;
                        state_d = ST_DONE;
                    end else begin
                        hi_d    = '0;
                        lo_d    = neg_a_in ? -A : A;
                        opb_d   = neg_b_in ? -B : B;
                        neg_a_d = neg_a_in;
                        neg_b_d = neg_b_in;
                        cnt_d   = CNT_W'(XLEN);
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = result_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ALU_result = res_q;
    assign zero       = (res_q == '0);

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter XLEN, default 32: operand and result width, even, >= 8.
REQ-002 Parameter CNT_W, default $clog2(XLEN)+1: iteration counter width.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 A, B  input  XLEN  operands, rs1 and rs2; sampled with start.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 ALU_result  output  XLEN  registered result; held until the next accepted start.
REQ-011 zero  output  1  high when ALU_result == 0; combinational from the register.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 IDLE with start=1 -> CALC: latch op, latch |A| and |B| according to op signedness, latch the sign flags, and set the counter to XLEN.
REQ-014 CALC SHALL perform one radix-2 step per edge and decrement the counter; the edge at which the counter reaches 0 -> DONE.
REQ-015 Multiply SHALL use shift-add on a 2*XLEN product register; divide SHALL use restoring shift-subtract producing quotient and remainder.
REQ-016 Sign correction SHALL be applied when ALU_result is written on the CALC->DONE edge.
REQ-017 DONE SHALL assert done=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-018 Normal latency: done high in the cycle following the XLENth edge after the edge that sampled start.
REQ-019 Output selection: MUL gives the low XLEN bits; MULH/MULHSU/MULHU give the high XLEN bits.
REQ-020 Output selection: DIV/DIVU give the quotient; REM/REMU give the remainder.
REQ-021 Remainder sign SHALL equal the sign of A; quotient rounding SHALL be toward zero.
REQ-022 Divide by zero (B==0, div ops) SHALL take the fast path IDLE->DONE at the sampling edge: quotient all ones, remainder A.
REQ-023 Signed overflow (DIV/REM, A==signed min, B==all ones) SHALL take the fast path: quotient A, remainder 0.
REQ-024 start in CALC or DONE SHALL be ignored, with no queuing.
REQ-025 op, A and B changes after the sampling edge SHALL have no effect on the running operation.
REQ-026 ALU_result SHALL change only on the CALC->DONE edge or a fast-path edge.

Reset
REQ-027 RST=1 at any edge SHALL force IDLE, busy=0, done=0, ALU_result=0 (zero=1) and counter=0, including mid-CALC and in DONE.
REQ-028 RST SHALL take priority over start in the same cycle; the aborted operation produces no done.

Structure
REQ-029 Package alu_pkg SHALL hold the op enum (funct3 encodings), the state enum and the XLEN default constant.
REQ-030 One sub-module, muldiv_step, SHALL be used: a combinational single iteration, parametrised by XLEN, muxing add-shift and subtract-shift.
REQ-031 The design SHALL contain no multiplier or divider operators; RTL SHALL be 120-400 lines.

Verification (XLEN=32)
REQ-032 MUL, A=7, B=0xFFFFFFFD -> ALU_result=0xFFFFFFEB, done exactly 32 edges after start, busy high throughout.
REQ-033 MULH, A=B=0x80000000 -> 0x40000000; MULHSU, A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF; MULHU with the same operands -> 0xFFFFFFFE.
REQ-034 REM, A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFF; DIV with the same operands -> 0xFFFFFFFD (-3).
REQ-035 DIVU, A=100, B=0 -> 0xFFFFFFFF, done 1 edge after start; REM, A=100, B=0 -> 100; DIV, A=0x80000000, B=0xFFFFFFFF -> 0x80000000, done after 1 edge.
REQ-036 DIVU, A=10, B=3; second start at cycle 5 with A=99 -> result 3, single done pulse, second start ignored.
REQ-037 RST at cycle 10 of a MUL -> busy=0, ALU_result=0, zero=1 next cycle, no done; a new start then completes normally.
